// File: rtl/waterbear_core_p.sv
// waterbear_core_p: multi-cycle accumulator CPU (IF/ID/EX/WB, 4 cycles/instr), internal data memory, debug read port.
// Optional JZ instruction (opcode 8) enabled by defining WATERBEAR_JZ_EN; otherwise opcode 8 is undefined.
module waterbear_core_p #(
  parameter int DW  = 8,
  parameter int AW  = 8,
  parameter int DAW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic [AW-1:0]  imem_addr,
  input  logic [15:0]    imem_rdata,
  output logic [AW-1:0]  pc,
  output logic [DW-1:0]  acc,
  output logic           zflag,
  output logic           cflag,
  output logic           halted,
  output logic           illegal,
  input  logic [DAW-1:0] dbg_addr,
  output logic [DW-1:0]  dbg_rdata
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_WB, S_HALT} state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDR = 4'h1;
  localparam logic [3:0] OP_STR = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_EQU = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, npc_q, npc_d;
  logic [DW-1:0] acc_q, acc_d, opv_q, opv_d, res_q, res_d;
  logic          z_q, z_d, c_q, c_d, nz_q, nz_d, nc_q, nc_d, we_q, we_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] dmem_q [2**DAW];

  logic           dm_we;
  logic           illegal_c;
  logic [3:0]     opcode;
  logic [DAW-1:0] dm_addr;
  logic [DW-1:0]  imm_val;
  logic [AW-1:0]  jmp_tgt;
  logic [DW:0]    sum;

  assign opcode  = ir_q[15:12];
  assign dm_addr = ir_q[DAW-1:0];
  assign imm_val = DW'(ir_q[10:0]);
  assign jmp_tgt = AW'(ir_q[10:0]);
  assign sum     = {1'b0, acc_q} + {1'b0, opv_q};

  // EX only fills the pending result registers (res/nz/nc/npc/we); WB is the sole commit point.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    z_d       = z_q;
    c_d       = c_q;
    ir_d      = ir_q;
    opv_d     = opv_q;
    res_d     = res_q;
    nz_d      = nz_q;
    nc_d      = nc_q;
    npc_d     = npc_q;
    we_d      = we_q;
    dm_we     = 1'b0;
    illegal_c = 1'b0;
    if (en) begin
      case (state_q)
        S_IF: begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = S_ID;
        end
        S_ID: begin
          opv_d   = ir_q[11] ? imm_val : dmem_q[dm_addr];
          state_d = S_EX;
        end
        S_EX: begin
          res_d   = acc_q;
          nz_d    = z_q;
          nc_d    = c_q;
          npc_d   = pc_q;
          we_d    = 1'b0;
          state_d = S_WB;
          case (opcode)
            OP_NOP: ;
            OP_LDR: begin
              res_d = opv_q;
              nz_d  = (opv_q == '0);
            end
            OP_STR: we_d = 1'b1;
            OP_ADD: begin
              res_d = sum[DW-1:0];
              nc_d  = sum[DW];
              nz_d  = (sum[DW-1:0] == '0);
            end
            OP_SUB: begin
              res_d = acc_q - opv_q;
              nc_d  = (acc_q < opv_q);
              nz_d  = (acc_q == opv_q);
            end
            OP_EQU: nz_d = (acc_q == opv_q);
            OP_JMP: npc_d = jmp_tgt;
            OP_HLT: state_d = S_HALT;
`ifdef WATERBEAR_JZ_EN
            OP_JZ:  if (z_q) npc_d = jmp_tgt;
`else
            OP_JZ:  illegal_c = 1'b1;
`endif
            default: illegal_c = 1'b1;
          endcase
        end
        S_WB: begin
          acc_d   = res_q;
          z_d     = nz_q;
          c_d     = nc_q;
          pc_d    = npc_q;
          dm_we   = we_q;
          state_d = S_IF;
        end
        S_HALT: ;
        default: state_d = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      pc_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ir_q    <= '0;
      opv_q   <= '0;
      res_q   <= '0;
      nz_q    <= 1'b0;
      nc_q    <= 1'b0;
      npc_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ir_q    <= ir_d;
      opv_q   <= opv_d;
      res_q   <= res_d;
      nz_q    <= nz_d;
      nc_q    <= nc_d;
      npc_q   <= npc_d;
      we_q    <= we_d;
    end
  end

  // Data memory keeps its contents across reset; only the in-flight store is dropped.
  always_ff @(posedge clk) begin
    if (!rst && dm_we) dmem_q[dm_addr] <= acc_q;
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign zflag     = z_q;
  assign cflag     = c_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_c & ~rst;
  assign dbg_rdata = dmem_q[dbg_addr];

endmodule

// File: tb/tb_waterbear_core_p.sv
// Bench for waterbear_core_p (DW=8, AW=8, DAW=6): directed scenarios plus random programs
// checked against an instruction-level model of the ISA.
module tb_waterbear_core_p;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  imem_addr, pc, acc, dbg_rdata;
  logic [15:0] imem_rdata;
  logic        zflag, cflag, halted, illegal;
  logic [5:0]  dbg_addr;

  logic [15:0] prog [256];
  assign imem_rdata = prog[imem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  // instruction-level model state
  logic [7:0] m_pc, m_acc;
  logic       m_z, m_c, m_halt;
  logic [7:0] m_dmem [64];

  waterbear_core_p #(.DW(8), .AW(8), .DAW(6)) dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .acc(acc), .zflag(zflag), .cflag(cflag),
    .halted(halted), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ins(input logic [3:0] op, input logic imm, input logic [10:0] opd);
    return {op, imm, opd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    m_pc = 8'd0; m_acc = 8'd0; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  // Executes one whole instruction at the architectural level.
  task automatic model_exec(output bit undef);
    logic [15:0] w;
    logic [7:0]  opv;
    logic [8:0]  s;
    w = prog[m_pc];
    undef = 1'b0;
    m_pc = m_pc + 8'd1;
    opv = w[11] ? w[7:0] : m_dmem[w[5:0]];
    case (w[15:12])
      4'd0: ;
      4'd1: begin m_acc = opv; m_z = (opv == 8'd0); end
      4'd2: m_dmem[w[5:0]] = m_acc;
      4'd3: begin s = {1'b0, m_acc} + {1'b0, opv}; m_acc = s[7:0]; m_c = s[8]; m_z = (m_acc == 8'd0); end
      4'd4: begin m_c = (m_acc < opv); m_acc = m_acc - opv; m_z = (m_acc == 8'd0); end
      4'd5: m_z = (m_acc == opv);
      4'd6: m_pc = w[7:0];
      4'd7: m_halt = 1'b1;
`ifdef WATERBEAR_JZ_EN
      4'd8: if (m_z) m_pc = w[7:0];
`endif
      default: undef = 1'b1;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; dbg_addr = 6'd0;
    clear_prog();
    tick(); tick();
    n_checks++; if (pc !== 8'd0) $display("FAIL reset_pc got %0h want 0", pc); else n_pass++;
    n_checks++; if (acc !== 8'd0) $display("FAIL reset_acc got %0h want 0", acc); else n_pass++;
    n_checks++; if (zflag !== 1'b0 || cflag !== 1'b0) $display("FAIL reset_flags got z=%b c=%b want 0 0", zflag, cflag); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
    n_checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", illegal); else n_pass++;
    rst = 1'b0;
    model_reset();
    // zero all data memory via the core itself
    prog[0] = ins(4'd1, 1'b1, 11'd0);
    for (int k = 0; k < 64; k++) prog[1+k] = ins(4'd2, 1'b0, 11'(k));
    prog[65] = ins(4'd7, 1'b0, 11'd0);
    cycles(66*4);
    for (int k = 0; k < 64; k++) m_dmem[k] = 8'd0;
    n_checks++; if (halted !== 1'b1 || pc !== 8'd66) $display("FAIL init_halt got halted=%b pc=%0d want 1 66", halted, pc); else n_pass++;
    dbg_addr = 6'd63; #1;
    n_checks++; if (dbg_rdata !== 8'd0) $display("FAIL init_dmem63 got %0h want 0", dbg_rdata); else n_pass++;
    // reset asserted mid-EX of an in-flight ADD
    rst = 1'b1;
    clear_prog();
    prog[0] = ins(4'd1, 1'b1, 11'd200);
    prog[1] = ins(4'd3, 1'b1, 11'd100);
    prog[2] = ins(4'd5, 1'b1, 11'd44);
    prog[3] = ins(4'd3, 1'b1, 11'd1);
    tick(); tick();
    rst = 1'b0;
    cycles(12);
    n_checks++; if (acc !== 8'd44 || zflag !== 1'b1 || cflag !== 1'b1) $display("FAIL pre_rst got acc=%0d z=%b c=%b want 44 1 1", acc, zflag, cflag); else n_pass++;
    cycles(2);
    n_checks++; if (pc !== 8'd4 || acc !== 8'd44) $display("FAIL ex_nocommit got pc=%0d acc=%0d want 4 44", pc, acc); else n_pass++;
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (pc !== 8'd0 || acc !== 8'd0 || zflag !== 1'b0 || cflag !== 1'b0 || halted !== 1'b0)
      $display("FAIL midex_rst got pc=%0d acc=%0d z=%b c=%b h=%b want 0 0 0 0 0", pc, acc, zflag, cflag, halted); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (pc !== 8'd1) $display("FAIL rst_then_if got pc=%0d want 1", pc); else n_pass++;
  endtask

  task automatic test_program();
    clear_prog();
    prog[0] = ins(4'd1, 1'b1, 11'd5);
    prog[1] = ins(4'd2, 1'b0, 11'd13);
    prog[2] = ins(4'd1, 1'b1, 11'd7);
    prog[3] = ins(4'd3, 1'b0, 11'd13);
    prog[4] = ins(4'd2, 1'b0, 11'd15);
    prog[5] = ins(4'd7, 1'b0, 11'd0);
    do_reset();
    cycles(20);
    n_checks++; if (halted !== 1'b0) $display("FAIL prog_early_halt got %b want 0", halted); else n_pass++;
    cycles(4);
    m_dmem[13] = 8'd5; m_dmem[15] = 8'd12;
    n_checks++; if (halted !== 1'b1 || pc !== 8'd6) $display("FAIL prog_halt got halted=%b pc=%0d want 1 6", halted, pc); else n_pass++;
    n_checks++; if (acc !== 8'd12) $display("FAIL prog_acc got %0d want 12", acc); else n_pass++;
    dbg_addr = 6'd15; #1;
    n_checks++; if (dbg_rdata !== 8'd12) $display("FAIL prog_dmem15 got %0d want 12", dbg_rdata); else n_pass++;
    dbg_addr = 6'd13; #1;
    n_checks++; if (dbg_rdata !== 8'd5) $display("FAIL prog_dmem13 got %0d want 5", dbg_rdata); else n_pass++;
    cycles(8);
    n_checks++; if (halted !== 1'b1 || pc !== 8'd6) $display("FAIL halt_absorb got halted=%b pc=%0d want 1 6", halted, pc); else n_pass++;
  endtask

  task automatic test_arith();
    clear_prog();
    prog[0] = ins(4'd1, 1'b1, 11'd200);
    prog[1] = ins(4'd3, 1'b1, 11'd100);
    prog[2] = ins(4'd4, 1'b1, 11'd44);
    prog[3] = ins(4'd4, 1'b1, 11'd1);
    prog[4] = ins(4'd1, 1'b1, 11'd3);
    prog[5] = ins(4'd5, 1'b1, 11'd3);
    do_reset();
    cycles(7);
    n_checks++; if (acc !== 8'd200 || cflag !== 1'b0) $display("FAIL add_in_ex got acc=%0d c=%b want 200 0", acc, cflag); else n_pass++;
    tick();
    n_checks++; if (acc !== 8'd44 || cflag !== 1'b1 || zflag !== 1'b0) $display("FAIL add_carry got acc=%0d c=%b z=%b want 44 1 0", acc, cflag, zflag); else n_pass++;
    cycles(4);
    n_checks++; if (acc !== 8'd0 || cflag !== 1'b0 || zflag !== 1'b1) $display("FAIL sub_zero got acc=%0d c=%b z=%b want 0 0 1", acc, cflag, zflag); else n_pass++;
    cycles(4);
    n_checks++; if (acc !== 8'd255 || cflag !== 1'b1 || zflag !== 1'b0) $display("FAIL sub_borrow got acc=%0d c=%b z=%b want 255 1 0", acc, cflag, zflag); else n_pass++;
    cycles(8);
    n_checks++; if (acc !== 8'd3 || zflag !== 1'b1 || cflag !== 1'b1) $display("FAIL equ got acc=%0d z=%b c=%b want 3 1 1", acc, zflag, cflag); else n_pass++;
  endtask

  task automatic test_jmp_en();
    clear_prog();
    prog[0] = ins(4'd6, 1'b0, 11'd2);
    prog[1] = ins(4'd1, 1'b1, 11'd99);
    prog[2] = ins(4'd1, 1'b1, 11'd7);
    do_reset();
    cycles(4);
    n_checks++; if (imem_addr !== 8'd2) $display("FAIL jmp_addr got %0d want 2", imem_addr); else n_pass++;
    cycles(2);
    en = 1'b0;
    cycles(5);
    n_checks++; if (pc !== 8'd3 || acc !== 8'd0 || zflag !== 1'b0 || halted !== 1'b0) $display("FAIL en_freeze got pc=%0d acc=%0d z=%b want 3 0 0", pc, acc, zflag); else n_pass++;
    en = 1'b1;
    cycles(2);
    n_checks++; if (acc !== 8'd7 || pc !== 8'd3) $display("FAIL en_resume got acc=%0d pc=%0d want 7 3", acc, pc); else n_pass++;
  endtask

  task automatic test_illegal();
    bit exp_ill;
`ifdef WATERBEAR_JZ_EN
    exp_ill = 1'b0;
`else
    exp_ill = 1'b1;
`endif
    clear_prog();
    prog[0]    = ins(4'd1, 1'b1, 11'd5);
    prog[1]    = ins(4'hF, 1'b1, 11'h0FF);
    prog[2]    = ins(4'd5, 1'b1, 11'd5);
    prog[3]    = ins(4'd8, 1'b1, 11'h010);
    prog[4]    = ins(4'd5, 1'b1, 11'd6);
    prog[5]    = ins(4'd8, 1'b1, 11'h030);
    prog[8'h10] = ins(4'd5, 1'b1, 11'd6);
    prog[8'h11] = ins(4'd8, 1'b1, 11'h030);
    do_reset();
    cycles(4);
    n_checks++; if (illegal !== 1'b0) $display("FAIL ill_if got %b want 0", illegal); else n_pass++;
    tick();
    n_checks++; if (illegal !== 1'b0) $display("FAIL ill_id got %b want 0", illegal); else n_pass++;
    tick();
    en = 1'b0; #1;
    n_checks++; if (illegal !== 1'b0) $display("FAIL ill_en0 got %b want 0", illegal); else n_pass++;
    tick();
    en = 1'b1; #1;
    n_checks++; if (illegal !== 1'b1) $display("FAIL ill_ex got %b want 1", illegal); else n_pass++;
    tick();
    n_checks++; if (illegal !== 1'b0) $display("FAIL ill_wb got %b want 0", illegal); else n_pass++;
    tick();
    n_checks++; if (acc !== 8'd5 || pc !== 8'd2 || zflag !== 1'b0) $display("FAIL ill_nop got acc=%0d pc=%0d z=%b want 5 2 0", acc, pc, zflag); else n_pass++;
    cycles(4 + 2);
    n_checks++; if (illegal !== exp_ill) $display("FAIL op8_ill got %b want %b", illegal, exp_ill); else n_pass++;
    cycles(2);
`ifdef WATERBEAR_JZ_EN
    n_checks++; if (pc !== 8'h10 || zflag !== 1'b1) $display("FAIL jz_taken got pc=%0h z=%b want 10 1", pc, zflag); else n_pass++;
    cycles(8);
    n_checks++; if (pc !== 8'h12 || zflag !== 1'b0) $display("FAIL jz_fall got pc=%0h z=%b want 12 0", pc, zflag); else n_pass++;
`else
    n_checks++; if (pc !== 8'd4 || zflag !== 1'b1) $display("FAIL op8_nop got pc=%0h z=%b want 4 1", pc, zflag); else n_pass++;
    cycles(8);
    n_checks++; if (pc !== 8'd6 || zflag !== 1'b0) $display("FAIL op8_nop2 got pc=%0h z=%b want 6 0", pc, zflag); else n_pass++;
`endif
  endtask

  task automatic test_pc_wrap();
    clear_prog();
    do_reset();
    cycles(255*4);
    n_checks++; if (imem_addr !== 8'd255) $display("FAIL wrap_255 got %0d want 255", imem_addr); else n_pass++;
    cycles(4);
    n_checks++; if (imem_addr !== 8'd0) $display("FAIL wrap_0 got %0d want 0", imem_addr); else n_pass++;
  endtask

  task automatic test_random();
    bit         undef;
    logic [3:0] op;
    int         bad = 0;
    for (int a = 0; a < 256; a++) begin
      op = 4'($urandom_range(15));
      if (op == 4'd7 && $urandom_range(3) != 0) op = 4'd1;
      prog[a] = ins(op, 1'($urandom_range(1)), 11'($urandom_range(2047)));
    end
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_halt) begin
        n_checks++; if (halted !== 1'b1 || pc !== m_pc) $display("FAIL rnd_halt n=%0d got h=%b pc=%0d want 1 %0d", n, halted, pc, m_pc); else n_pass++;
        do_reset();
      end
      model_exec(undef);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(7) == 0) begin
          en = 1'b0; #1;
          n_checks++; if (illegal !== 1'b0) $display("FAIL rnd_stall_ill n=%0d k=%0d got %b want 0", n, k, illegal); else n_pass++;
          tick();
          en = 1'b1; #1;
        end
        if (k == 2) begin
          n_checks++; if (illegal !== undef) $display("FAIL rnd_ill n=%0d got %b want %b", n, illegal, undef); else n_pass++;
        end
        tick();
      end
      dbg_addr = 6'($urandom_range(63)); #1;
      n_checks++;
      if (pc !== m_pc || acc !== m_acc || zflag !== m_z || cflag !== m_c || halted !== m_halt || dbg_rdata !== m_dmem[dbg_addr]) begin
        if (bad < 10) $display("FAIL rnd_state n=%0d got pc=%0d acc=%0d z=%b c=%b h=%b d=%0d want %0d %0d %b %b %b %0d",
                               n, pc, acc, zflag, cflag, halted, dbg_rdata, m_pc, m_acc, m_z, m_c, m_halt, m_dmem[dbg_addr]);
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dbg_addr = 6'd0;
    test_reset();
    test_program();
    test_arith();
    test_jmp_en();
    test_illegal();
    test_pc_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
